pipe_maindec: RTL

Parametrised main decoder with built-in control pipeline for the pipelined MIPS core. Decodes the Decode-stage opcode into the full control word. Carries the per-stage subsets through ID/EX, EX/MEM and MEM/WB registers, with flush for hazard bubbles. Replaces X on illegal opcodes with a safe bubble, a sticky flag and a saturating counter.

---
 rtl/pipe_maindec_if.sv | 63 ++++++
 rtl/pipe_maindec.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_maindec_if.sv
// pipe_maindec_if: control-plane bundle between the pipeline datapath and
// the main decoder.
//   master : drives op_d, valid_d, flush_e, clr_illegal and receives every
//            decoded control (Decode, E, M and W stage) plus the illegal status.
//   slave  : the decoder side of the same bundle.
// ALUOP_W and CNT_W must match the pipe_maindec instance that uses it.
interface pipe_maindec_if #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 8
);
  // Decode-stage request
  logic [5:0]         op_d;
  logic               valid_d;
  logic               flush_e;
  logic               clr_illegal;
  // Decode-stage combinational controls
  logic               branch_d;
  logic               bne_d;
  logic               jump_d;
  logic               illegal_d;
  // ID/EX
  logic               regwrite_e;
  logic               memtoreg_e;
  logic               memwrite_e;
  logic               alusrc_e;
  logic               regdst_e;
  logic               zeroext_e;
  logic               link_e;
  logic               valid_e;
  logic [ALUOP_W-1:0] aluop_e;
  // EX/MEM
  logic               regwrite_m;
  logic               memtoreg_m;
  logic               memwrite_m;
  logic               link_m;
  // MEM/WB
  logic               regwrite_w;
  logic               memtoreg_w;
  logic               link_w;
  // illegal-opcode status
  logic               illegal_sticky;
  logic [CNT_W-1:0]   illegal_cnt;

  modport master (
    output op_d, valid_d, flush_e, clr_illegal,
    input  branch_d, bne_d, jump_d, illegal_d,
    input  regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e,
    input  zeroext_e, link_e, valid_e, aluop_e,
    input  regwrite_m, memtoreg_m, memwrite_m, link_m,
    input  regwrite_w, memtoreg_w, link_w,
    input  illegal_sticky, illegal_cnt
  );

  modport slave (
    input  op_d, valid_d, flush_e, clr_illegal,
    output branch_d, bne_d, jump_d, illegal_d,
    output regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e,
    output zeroext_e, link_e, valid_e, aluop_e,
    output regwrite_m, memtoreg_m, memwrite_m, link_m,
    output regwrite_w, memtoreg_w, link_w,
    output illegal_sticky, illegal_cnt
  );
endinterface

// File: rtl/pipe_maindec.sv
// pipe_maindec: MIPS main decoder with its ID/EX, EX/MEM and MEM/WB control
// registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears every registered output
//   bus   : pipe_maindec_if.slave (opcode/valid/flush/clear in, controls out)
// Illegal or invalid opcodes produce an all-zero control word (a bubble),
// set illegal_sticky and bump a saturating illegal_cnt.
// Optional: define PIPE_MAINDEC_EXT_EN to decode bne/andi/ori/slti/jal;
// otherwise those opcodes are illegal and bne_d is tied low.
module pipe_maindec #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  pipe_maindec_if.slave  bus
);

  typedef struct packed {
    logic               regwrite;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regdst;
    logic               zeroext;
    logic               link;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
    logic link;
  } ctrl_m_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic link;
  } ctrl_w_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'd2);
`ifdef PIPE_MAINDEC_EXT_EN
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'd5);
`endif
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  ctrl_t   raw, ctrl_d, ctrl_e;
  ctrl_m_t ctrl_m;
  ctrl_w_t ctrl_w;
  logic    known, br_raw, jmp_raw, live_d;
  logic    valid_e;
  logic    illegal_ev;
  logic    sticky;
  logic [CNT_W-1:0] cnt;
`ifdef PIPE_MAINDEC_EXT_EN
  logic    bne_raw;
`endif

  // ---------------- Decode ----------------
  always_comb begin
    raw     = '0;
    br_raw  = 1'b0;
    jmp_raw = 1'b0;
    known   = 1'b1;
`ifdef PIPE_MAINDEC_EXT_EN
    bne_raw = 1'b0;
`endif
    case (bus.op_d)
      6'b000000: begin raw.regwrite = 1'b1; raw.regdst = 1'b1; raw.aluop = ALU_FUNCT; end
      6'b100011: begin
        raw.regwrite = 1'b1; raw.alusrc = 1'b1; raw.memtoreg = 1'b1; raw.aluop = ALU_ADD;
      end
      6'b101011: begin raw.alusrc = 1'b1; raw.memwrite = 1'b1; raw.aluop = ALU_ADD; end
      6'b000100: begin br_raw = 1'b1; raw.aluop = ALU_SUB; end
      6'b001000: begin raw.regwrite = 1'b1; raw.alusrc = 1'b1; raw.aluop = ALU_ADD; end
      6'b000010: jmp_raw = 1'b1;
`ifdef PIPE_MAINDEC_EXT_EN
      6'b000101: begin bne_raw = 1'b1; raw.aluop = ALU_SUB; end
      6'b001100: begin
        raw.regwrite = 1'b1; raw.alusrc = 1'b1; raw.zeroext = 1'b1; raw.aluop = ALU_AND;
      end
      6'b001101: begin
        raw.regwrite = 1'b1; raw.alusrc = 1'b1; raw.zeroext = 1'b1; raw.aluop = ALU_OR;
      end
      6'b001010: begin raw.regwrite = 1'b1; raw.alusrc = 1'b1; raw.aluop = ALU_SLT; end
      6'b000011: begin jmp_raw = 1'b1; raw.regwrite = 1'b1; raw.link = 1'b1; end
`endif
      default:   known = 1'b0;
    endcase
  end

  // Anything not a valid, decodable instruction becomes a clean bubble.
  assign live_d    = bus.valid_d & known;
  assign ctrl_d    = live_d ? raw : '0;

  assign bus.branch_d  = live_d & br_raw;
  assign bus.jump_d    = live_d & jmp_raw;
  assign bus.illegal_d = bus.valid_d & ~known;
`ifdef PIPE_MAINDEC_EXT_EN
  assign bus.bne_d     = live_d & bne_raw;
`else
  assign bus.bne_d     = 1'b0;
`endif

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e  <= '0;
      valid_e <= 1'b0;
      ctrl_m  <= '0;
      ctrl_w  <= '0;
    end else begin
      // flush beats everything: ID/EX takes a bubble
      ctrl_e  <= bus.flush_e ? '0   : ctrl_d;
      valid_e <= bus.flush_e ? 1'b0 : live_d;
      ctrl_m  <= '{regwrite: ctrl_e.regwrite, memtoreg: ctrl_e.memtoreg,
                   memwrite: ctrl_e.memwrite, link: ctrl_e.link};
      ctrl_w  <= '{regwrite: ctrl_m.regwrite, memtoreg: ctrl_m.memtoreg,
                   link: ctrl_m.link};
    end
  end

  // ---------------- Illegal-opcode status ----------------
  // A flushed Decode slot is re-presented next cycle, so it is not counted.
  assign illegal_ev = bus.illegal_d & ~bus.flush_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (illegal_ev) begin
      // a same-cycle clear restarts the count at this event
      sticky <= 1'b1;
      if (bus.clr_illegal)   cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end else if (bus.clr_illegal) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end
  end

  // ---------------- Outputs ----------------
  assign bus.regwrite_e     = ctrl_e.regwrite;
  assign bus.memtoreg_e     = ctrl_e.memtoreg;
  assign bus.memwrite_e     = ctrl_e.memwrite;
  assign bus.alusrc_e       = ctrl_e.alusrc;
  assign bus.regdst_e       = ctrl_e.regdst;
  assign bus.zeroext_e      = ctrl_e.zeroext;
  assign bus.link_e         = ctrl_e.link;
  assign bus.aluop_e        = ctrl_e.aluop;
  assign bus.valid_e        = valid_e;
  assign bus.regwrite_m     = ctrl_m.regwrite;
  assign bus.memtoreg_m     = ctrl_m.memtoreg;
  assign bus.memwrite_m     = ctrl_m.memwrite;
  assign bus.link_m         = ctrl_m.link;
  assign bus.regwrite_w     = ctrl_w.regwrite;
  assign bus.memtoreg_w     = ctrl_w.memtoreg;
  assign bus.link_w         = ctrl_w.link;
  assign bus.illegal_sticky = sticky;
  assign bus.illegal_cnt    = cnt;

endmodule
